// File: rtl/bennett_pkg.sv
// rtl/bennett_pkg.sv - shared defaults, step type and phase-step constants for the Bennett SRAM bank
package bennett_pkg;

    localparam int DEF_WIDTH  = 10;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;

    // Wide enough for 2*WIDTH steps up to WIDTH = 128
    localparam int STEP_W = 8;
    typedef logic [STEP_W-1:0] step_t;

    // Each constant names the step whose closing clk edge performs the action
    localparam step_t ADDR_STEP  = step_t'(3);
    localparam step_t DATA_STEP  = step_t'(5);
    localparam step_t READ_STEP  = step_t'(7);
    localparam step_t WRITE_STEP = step_t'(9);

endpackage

// File: rtl/bennett_phase_gen.sv
// rtl/bennett_phase_gen.sv - square-wave Bennett phase-clock generator (step counter, clkp, mclk, inst_flag)
// Ports: clk, reset (async active-low), step (current step s), clkp[WIDTH-1:0] phase clocks,
//        mclk (high in rising half), inst_flag (high at s=0), clkn (only with BENNETT_CLKN_EN).
// Optional macro BENNETT_CLKN_EN adds clkn = ~clkp from its own register.
module bennett_phase_gen
    import bennett_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output step_t            step,
    output logic [WIDTH-1:0] clkp,
`ifdef BENNETT_CLKN_EN
    output logic [WIDTH-1:0] clkn,
`endif
    output logic             mclk,
    output logic             inst_flag
);

    localparam step_t LAST_STEP = step_t'(2*WIDTH-1);

    // active is low only between reset release and the first edge, so that
    // the first edge enters s=0 instead of advancing to s=1.
    logic             active;
    step_t            step_d;
    logic [WIDTH-1:0] clkp_d;

    // Outputs are registered from the next step so they line up with step.
    always_comb begin
        step_d = '0;
        clkp_d = '0;
        if (active && (step != LAST_STEP)) begin
            step_d = step + step_t'(1);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(step_d) < WIDTH) begin
                clkp_d[i] = (i <= int'(step_d));
            end else begin
                clkp_d[i] = (i < 2*WIDTH - 1 - int'(step_d));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step      <= '0;
            active    <= 1'b0;
            clkp      <= '0;
`ifdef BENNETT_CLKN_EN
            clkn      <= '1;
`endif
            mclk      <= 1'b0;
            inst_flag <= 1'b0;
        end else begin
            step      <= step_d;
            active    <= 1'b1;
            clkp      <= clkp_d;
`ifdef BENNETT_CLKN_EN
            clkn      <= ~clkp_d;
`endif
            mclk      <= (int'(step_d) < WIDTH);
            inst_flag <= (step_d == '0);
        end
    end

endmodule

// File: rtl/bennett_sram_2port_bank.sv
// rtl/bennett_sram_2port_bank.sv - 32x16 register bank, port A read/write, port B read-only, phase-step sequenced
// Ports: clk, reset (async active-low), addr_a/addr_b, wdata, read_en, reg_wrt_bar, write_en,
//        out_a/out_b read data, clkp phase clocks, mclk, inst_flag, clkn (only with BENNETT_CLKN_EN).
// Optional macro BENNETT_CLKN_EN exposes the complementary phase clocks.
module bennett_sram_2port_bank
    import bennett_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read_en,
    input  logic              reg_wrt_bar,
    input  logic              write_en,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [WIDTH-1:0]  clkp,
`ifdef BENNETT_CLKN_EN
    output logic [WIDTH-1:0]  clkn,
`endif
    output logic              mclk,
    output logic              inst_flag
);

    step_t step;

    bennett_phase_gen #(.WIDTH(WIDTH)) u_phase_gen (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .clkp      (clkp),
`ifdef BENNETT_CLKN_EN
        .clkn      (clkn),
`endif
        .mclk      (mclk),
        .inst_flag (inst_flag)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wrt_q;

    // Restore strobe: phase 6 high while the phases are falling. The write
    // qualifier is spent by then, so it is returned to 0 here.
    logic srclk;
    assign srclk = clkp[6] & ~mclk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            addr_a_q <= '0;
            addr_b_q <= '0;
            wdata_q  <= '0;
            wrt_q    <= 1'b0;
            out_a    <= '0;
            out_b    <= '0;
        end else begin
            if (step == ADDR_STEP) begin
                addr_a_q <= addr_a;
                addr_b_q <= addr_b;
            end
            if (step == DATA_STEP) begin
                wdata_q <= wdata;
            end
            // read_en acts on the same edge that samples it
            if (step == READ_STEP) begin
                wrt_q <= reg_wrt_bar;
                if (read_en) begin
                    out_a <= mem[addr_a_q];
                    out_b <= mem[addr_b_q];
                end
            end else if (srclk) begin
                wrt_q <= 1'b0;
            end
            // Write lands two steps after the read, so a same-cycle read sees old data
            if ((step == WRITE_STEP) && write_en && wrt_q) begin
                mem[addr_a_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_bennett_sram_2port_bank.sv
// tb/tb_bennett_sram_2port_bank.sv - self-checking bench for bennett_sram_2port_bank
module tb_bennett_sram_2port_bank;

    localparam int W  = 10;
    localparam int NW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr_a, addr_b;
    logic [15:0] wdata;
    logic        read_en, reg_wrt_bar, write_en;
    logic [15:0] out_a, out_b;
    logic [W-1:0] clkp;
`ifdef BENNETT_CLKN_EN
    logic [W-1:0] clkn;
`endif
    logic        mclk, inst_flag;

    int tests = 0;
    int fails = 0;

    logic [15:0] mm [NW];
    logic [15:0] exp_a, exp_b;

    always #5 clk = ~clk;

    bennett_sram_2port_bank dut (
        .clk         (clk),
        .reset       (reset),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .wdata       (wdata),
        .read_en     (read_en),
        .reg_wrt_bar (reg_wrt_bar),
        .write_en    (write_en),
        .out_a       (out_a),
        .out_b       (out_b),
        .clkp        (clkp),
`ifdef BENNETT_CLKN_EN
        .clkn        (clkn),
`endif
        .mclk        (mclk),
        .inst_flag   (inst_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            if (dut.mem[i] !== mm[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) mm[i] = '0;
        exp_a = '0;
        exp_b = '0;
    endtask

    function automatic logic [W-1:0] phase_exp(input int s);
        if (s < W) return W'((1 << (s + 1)) - 1);
        return W'((1 << (2*W - 1 - s)) - 1);
    endfunction

    // One instruction cycle starting in s=0. Inputs carry junk except at
    // the step where they are sampled. rst_at >= 0 pulls reset at that step.
    task automatic run_cycle(input logic [4:0] a, input logic [4:0] b, input logic [15:0] wd,
                             input logic re, input logic rwb, input logic we,
                             input bit chk_phase, input int rst_at);
        for (int s = 0; s < 2*W; s++) begin
            @(negedge clk);
            if (chk_phase) begin
                check($sformatf("clkp s=%0d", s), 32'(clkp), 32'(phase_exp(s)));
                check($sformatf("mclk s=%0d", s), 32'(mclk), 32'(s < W));
                check($sformatf("inst_flag s=%0d", s), 32'(inst_flag), 32'(s == 0));
`ifdef BENNETT_CLKN_EN
                check($sformatf("clkn s=%0d", s), 32'(clkn), 32'(~phase_exp(s)));
`endif
            end
            if (s == rst_at) begin
                reset = 1'b0;
                #1;
                model_reset();
                check("mid reset clkp", 32'(clkp), 0);
                check("mid reset mclk", 32'(mclk), 0);
                check("mid reset out_a", 32'(out_a), 0);
                check("mid reset out_b", 32'(out_b), 0);
                check_mem("mid reset mem");
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                return;
            end
            addr_a      = (s == 3) ? a   : 5'($urandom);
            addr_b      = (s == 3) ? b   : 5'($urandom);
            wdata       = (s == 5) ? wd  : 16'($urandom);
            read_en     = (s == 7) ? re  : 1'($urandom);
            reg_wrt_bar = (s == 7) ? rwb : 1'($urandom);
            write_en    = (s == 9) ? we  : 1'($urandom);
            @(posedge clk);
            if (s == 7 && re) begin
                exp_a = mm[a];
                exp_b = mm[b];
            end
            if (s == 9 && we && rwb) mm[a] = wd;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        addr_a = '0; addr_b = '0; wdata = '0;
        read_en = 1'b0; reg_wrt_bar = 1'b0; write_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset clkp", 32'(clkp), 0);
        check("reset mclk", 32'(mclk), 0);
        check("reset inst_flag", 32'(inst_flag), 0);
        check("reset out_a", 32'(out_a), 0);
        check("reset out_b", 32'(out_b), 0);
        check_mem("reset mem");
        reset = 1'b1;
        @(posedge clk);

        run_cycle(5'd1, 5'd31, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check_mem("write mem");

        run_cycle(5'd1, 5'd0, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("read out_a", 32'(out_a), 32'(exp_a));
        check("read out_a const", 32'(out_a), 32'h0000AAAA);
        check("read out_b", 32'(out_b), 32'(exp_b));
        check_mem("read mem");

        run_cycle(5'd2, 5'd2, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        check_mem("blocked mem");

        run_cycle(5'd1, 5'd1, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        check("rbw out_a", 32'(out_a), 32'h0000AAAA);
        check("rbw out_b", 32'(out_b), 32'h0000AAAA);
        run_cycle(5'd1, 5'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("after rbw out_a", 32'(out_a), 32'h00005555);
        check("after rbw out_b", 32'(out_b), 32'h00000000);
        check_mem("rbw mem");

        for (int n = 0; n < 40; n++) begin
            run_cycle(5'($urandom), 5'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                      (n == 20), -1);
            check($sformatf("rand%0d out_a", n), 32'(out_a), 32'(exp_a));
            check($sformatf("rand%0d out_b", n), 32'(out_b), 32'(exp_b));
        end
        check_mem("random mem");

        run_cycle(5'd3, 5'd4, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 8);
        run_cycle(5'd1, 5'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        check("post reset out_a", 32'(out_a), 0);
        check("post reset out_b", 32'(out_b), 0);
        check_mem("post reset mem");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
